// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - instruction memory read port between pc_sequencer and memory
interface pc_sequencer_if;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;

    modport master (
        output mem_read,
        output mem_addr,
        input  mem_waitrequest,
        input  mem_readdata
    );

    modport slave (
        input  mem_read,
        input  mem_addr,
        output mem_waitrequest,
        output mem_readdata
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/execute PC sequencer with delay slot and halt (optional PC_SEQ_ALIGN_CHECK_EN)
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pc_sequencer_if.master        mem,
    output logic [31:0]           instr,
    output logic                  instr_valid,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [31:0]           redirect_target,
    output logic [31:0]           pc,
    output logic [31:0]           link_addr,
    output logic                  active,
    output logic                  halted,
    output logic                  fault,
    output logic [31:0]           retired
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic        fault_q, fault_d;

    // State and datapath registers; reset abandons any outstanding fetch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_VECTOR;
            instr_q      <= 32'h0;
            retired_q    <= 32'h0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= 32'h0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            retired_q    <= retired_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            fault_q      <= fault_d;
        end
    end

    // Next state: fetch handshake, completion, delay-slot redirect bookkeeping
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        retired_d    = retired_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        fault_d      = fault_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (!mem.mem_waitrequest) begin
                    instr_d = mem.mem_readdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    retired_d = retired_q + 32'd1;
                    if (pend_valid_q) begin
                        // Delay slot finished: take the captured target, ignore any new redirect
                        pc_d         = pend_addr_q;
                        pend_valid_d = 1'b0;
                        state_d      = (pend_addr_q == HALT_ADDR) ? S_HALT : S_FETCH;
                    end else begin
`ifdef PC_SEQ_ALIGN_CHECK_EN
                        if (redirect && (redirect_target[1:0] != 2'b00)) begin
                            // Misaligned target stops the core before the delay slot runs
                            fault_d = 1'b1;
                            pc_d    = redirect_target;
                            state_d = S_HALT;
                        end else begin
                            pc_d    = pc_q + 32'd4;
                            state_d = S_FETCH;
                            if (redirect) begin
                                pend_addr_d  = redirect_target;
                                pend_valid_d = 1'b1;
                            end
                        end
`else
                        pc_d    = pc_q + 32'd4;
                        state_d = S_FETCH;
                        if (redirect) begin
                            pend_addr_d  = redirect_target & 32'hFFFF_FFFC;
                            pend_valid_d = 1'b1;
                        end
`endif
                    end
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        mem.mem_read = (state_q == S_FETCH);
        instr_valid  = (state_q == S_EXEC);
        active       = (state_q == S_FETCH) || (state_q == S_EXEC);
        halted       = (state_q == S_HALT);
    end

    assign mem.mem_addr = pc_q;
    assign pc           = pc_q;
    assign instr        = instr_q;
    assign retired      = retired_q;
    assign link_addr    = pc_q + 32'd8;
`ifdef PC_SEQ_ALIGN_CHECK_EN
    assign fault        = fault_q;
`else
    assign fault        = 1'b0;
`endif

endmodule
